// File: rtl/instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// instr_fetch_mem
//
// Synchronous instruction memory with a valid/ready fetch port and a 2-entry
// response buffer. Each accepted request reads FETCH_WIDTH consecutive 32-bit
// words. The result is captured into the response FIFO at the accepting edge,
// so it becomes visible one edge later. A word-wide load port writes program
// images at run time, and a load always takes priority over a fetch.
//
// Handshake semantics (both ports):
//   A transfer happens at a rising edge where valid && ready. A producer holds
//   valid until the transfer. A not-yet-accepted fetch may change its address;
//   only the address present at the accepting edge is used. req_ready_out never
//   depends combinationally on resp_ready_in.
//
// Optional feature (macro INSTR_MEM_FAULT_EN):
//   defined   -> misaligned or out-of-range fetch addresses return a faulted
//                response (instr = 0, count = 1, fault = 1).
//   undefined -> resp_fault_out is tied to 0. Address bits [1:0] are ignored
//                and the upper address bits alias.
//
// Parameters:
//   ADDR_WIDTH    fetch byte-address width
//   MEM_DEPTH_POW log2 of the number of 32-bit words
//   FETCH_WIDTH   instructions per request, 1 or 2
//
// Ports:
//   clk, rst_n                 clock; synchronous active-low reset
//   req_valid_in/req_ready_out fetch request handshake
//   req_addr_in                fetch byte address
//   resp_valid_out/resp_ready_in response handshake (head of FIFO)
//   resp_instr_out             lane 0 in [31:0], lane 1 in [63:32]
//   resp_count_out             number of valid lanes
//   resp_fault_out             faulted request, lanes meaningless
//   load_en_in/load_addr_in/load_data_in  word write port
// -----------------------------------------------------------------------------
module instr_fetch_mem #(
  parameter int ADDR_WIDTH    = 64,
  parameter int MEM_DEPTH_POW = 10,
  parameter int FETCH_WIDTH   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_in,
  output logic                      req_ready_out,
  input  logic [ADDR_WIDTH-1:0]     req_addr_in,
  output logic                      resp_valid_out,
  input  logic                      resp_ready_in,
  output logic [32*FETCH_WIDTH-1:0] resp_instr_out,
  output logic [1:0]                resp_count_out,
  output logic                      resp_fault_out,
  input  logic                      load_en_in,
  input  logic [MEM_DEPTH_POW-1:0]  load_addr_in,
  input  logic [31:0]               load_data_in
);

  localparam int          MEM_DEPTH = 1 << MEM_DEPTH_POW;
  localparam int          RW        = 32 * FETCH_WIDTH;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [RW-1:0] instr;
    logic [1:0]    count;
    logic          fault;
  } resp_t;

  // Storage: not reset, so program images survive a reset.
  logic [31:0] mem_q [MEM_DEPTH];

  // Two-slot FIFO: slot0 is always the head, slot1 only used when full.
  resp_t      slot0_q, slot0_d;
  resp_t      slot1_q, slot1_d;
  logic [1:0] count_q, count_d;

  logic [MEM_DEPTH_POW-1:0] idx;
  logic [31:0]              rd_lane0;
  logic [RW-1:0]            rd_instr;
  logic [1:0]               rd_count;
  logic                     addr_fault;
  resp_t                    rd_resp;
  logic                     push;
  logic                     pop;

  // ---------------------------------------------------------------------------
  // Address decode and fault detection
  // ---------------------------------------------------------------------------
  assign idx = req_addr_in[MEM_DEPTH_POW+1:2];

`ifdef INSTR_MEM_FAULT_EN
  assign addr_fault = (req_addr_in[1:0] != 2'b00) ||
                      (|req_addr_in[ADDR_WIDTH-1:MEM_DEPTH_POW+2]);
`else
  // Byte-offset and upper bits deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr_in[1:0],
                              req_addr_in[ADDR_WIDTH-1:MEM_DEPTH_POW+2]};
  assign addr_fault = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------
  assign rd_lane0 = mem_q[idx];

  generate
    if (FETCH_WIDTH == 2) begin : g_dual
      logic                     at_top;
      logic [MEM_DEPTH_POW-1:0] idx_next;
      logic [31:0]              rd_lane1;

      // The second lane does not wrap past the last word: it returns a NOP
      // and the response reports a single valid lane.
      assign at_top   = &idx;
      assign idx_next = idx + 1'b1;
      assign rd_lane1 = at_top ? NOP_INSTR : mem_q[idx_next];
      assign rd_instr = {rd_lane1, rd_lane0};
      assign rd_count = at_top ? 2'd1 : 2'd2;
    end else begin : g_single
      assign rd_instr = rd_lane0;
      assign rd_count = 2'd1;
    end
  endgenerate

  always_comb begin
    rd_resp = '0;
    if (addr_fault) begin
      rd_resp.count = 2'd1;
      rd_resp.fault = 1'b1;
    end else begin
      rd_resp.instr = rd_instr;
      rd_resp.count = rd_count;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign req_ready_out  = rst_n && !load_en_in && (count_q != 2'd2);
  assign resp_valid_out = (count_q != 2'd0);
  assign push           = req_valid_in && req_ready_out;
  assign pop            = resp_valid_out && resp_ready_in;

  // ---------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          slot0_d = rd_resp;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          slot0_d = rd_resp;
        end else if (push) begin
          slot1_d = rd_resp;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        // req_ready_out is low when full, so only a pop can happen here.
        if (pop) begin
          slot0_d = slot1_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en_in) begin
      mem_q[load_addr_in] <= load_data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: zero whenever the FIFO is empty, so reset values are all zero.
  // ---------------------------------------------------------------------------
  assign resp_instr_out = resp_valid_out ? slot0_q.instr : '0;
  assign resp_count_out = resp_valid_out ? slot0_q.count : 2'd0;
  assign resp_fault_out = resp_valid_out ? slot0_q.fault : 1'b0;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_mem
//
// Two instances share one set of inputs: a single-lane build and a dual-lane
// build (16-word memory, 16-bit addresses). Each cycle the request-ready output
// is sampled at the falling edge and the response outputs 1 time unit after the
// rising edge. A queue-based reference model checks every cycle. A directed
// vector table walks through the main scenarios, and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_instr_fetch_mem;

  localparam int AW  = 16;
  localparam int MDP = 4;

  // ---------------- clock / reset / inputs ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic              resp_ready = 1'b0;
  logic              load_en = 1'b0;
  logic [MDP-1:0]    load_addr = '0;
  logic [31:0]       load_data = '0;

  always #5 clk = ~clk;

  logic              ready1, ready2, valid1, valid2, fault1, fault2;
  logic [31:0]       instr1;
  logic [63:0]       instr2;
  logic [1:0]        count1, count2;

  instr_fetch_mem #(.ADDR_WIDTH(AW), .MEM_DEPTH_POW(MDP), .FETCH_WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(req_valid), .req_ready_out(ready1), .req_addr_in(req_addr),
    .resp_valid_out(valid1), .resp_ready_in(resp_ready),
    .resp_instr_out(instr1), .resp_count_out(count1), .resp_fault_out(fault1),
    .load_en_in(load_en), .load_addr_in(load_addr), .load_data_in(load_data)
  );

  instr_fetch_mem #(.ADDR_WIDTH(AW), .MEM_DEPTH_POW(MDP), .FETCH_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(req_valid), .req_ready_out(ready2), .req_addr_in(req_addr),
    .resp_valid_out(valid2), .resp_ready_in(resp_ready),
    .resp_instr_out(instr2), .resp_count_out(count2), .resp_fault_out(fault2),
    .load_en_in(load_en), .load_addr_in(load_addr), .load_data_in(load_data)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] l0;
    logic [31:0] l1;
    logic [1:0]  c1;
    logic [1:0]  c2;
    logic        f;
  } exp_t;

  logic [31:0] mdl_mem [16];
  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        ready_seen;

  function automatic exp_t model_read(input logic [AW-1:0] a);
    exp_t r;
    int   widx;
    r    = '0;
    widx = int'(a[5:2]);
`ifdef INSTR_MEM_FAULT_EN
    if (a[1:0] != 2'b00 || a >= 16'h0040) begin
      r.f  = 1'b1;
      r.c1 = 2'd1;
      r.c2 = 2'd1;
      return r;
    end
`endif
    r.l0 = mdl_mem[widx];
    r.c1 = 2'd1;
    if (widx == 15) begin
      r.l1 = 32'h0000_0013;
      r.c2 = 2'd1;
    end else begin
      r.l1 = mdl_mem[widx + 1];
      r.c2 = 2'd2;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle with the current inputs: checks ready before the edge,
  // advances the model, then checks the response outputs after the edge.
  task automatic do_cycle();
    logic m_ready;
    exp_t rd;
    exp_t h;
    bit   was_reset;
    @(negedge clk);
    m_ready    = rst_n && !load_en && (exp_q.size() < 2);
    ready_seen = ready1;
    check("req_ready_w1", {63'd0, ready1}, {63'd0, m_ready});
    check("req_ready_w2", {63'd0, ready2}, {63'd0, m_ready});
    rd        = model_read(req_addr);
    was_reset = !rst_n;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && resp_ready) void'(exp_q.pop_front());
      if (m_ready && req_valid) exp_q.push_back(rd);
    end
    if (load_en) mdl_mem[load_addr] = load_data;
    @(posedge clk);
    #1;
    check("resp_valid_w1", {63'd0, valid1}, {63'd0, exp_q.size() != 0});
    check("resp_valid_w2", {63'd0, valid2}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("instr_w1", {32'd0, instr1}, {32'd0, h.l0});
      check("count_w1", {62'd0, count1}, {62'd0, h.c1});
      check("fault_w1", {63'd0, fault1}, {63'd0, h.f});
      check("instr_w2", instr2, {h.l1, h.l0});
      check("count_w2", {62'd0, count2}, {62'd0, h.c2});
      check("fault_w2", {63'd0, fault2}, {63'd0, h.f});
    end else if (was_reset) begin
      check("rst_instr_w1", {32'd0, instr1}, 64'd0);
      check("rst_count_w1", {62'd0, count1}, 64'd0);
      check("rst_fault_w1", {63'd0, fault1}, 64'd0);
      check("rst_instr_w2", instr2, 64'd0);
      check("rst_count_w2", {62'd0, count2}, 64'd0);
      check("rst_fault_w2", {63'd0, fault2}, 64'd0);
    end
  endtask

  task automatic set_in(input logic r, input logic le, input logic [MDP-1:0] la,
                        input logic [31:0] ld, input logic rv, input logic [AW-1:0] ra,
                        input logic rr);
    rst_n      = r;
    load_en    = le;
    load_addr  = la;
    load_data  = ld;
    req_valid  = rv;
    req_addr   = ra;
    resp_ready = rr;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic           rst;
    logic           le;
    logic [MDP-1:0] la;
    logic [31:0]    ld;
    logic           rv;
    logic [AW-1:0]  ra;
    logic           rr;
    logic           e_ready;
    logic           e_valid;
    logic [31:0]    e_l0;
    logic [31:0]    e_l1;
    logic [1:0]     e_c1;
    logic [1:0]     e_c2;
  } vec_t;

  vec_t vecs [21];

  initial begin
    for (int i = 0; i < 16; i++) mdl_mem[i] = 32'd0;

    //          rst le la  ld        rv ra        rr  rdy val l0        l1        c1 c2
    vecs[0]  = '{0, 0, 0,  32'h0,    0, 16'h0000, 1,  0,  0,  32'h0,    32'h0,    0, 0};
    vecs[1]  = '{1, 1, 0,  32'h11,   0, 16'h0000, 1,  0,  0,  32'h0,    32'h0,    0, 0};
    vecs[2]  = '{1, 1, 1,  32'h22,   0, 16'h0000, 1,  0,  0,  32'h0,    32'h0,    0, 0};
    vecs[3]  = '{1, 1, 2,  32'h33,   0, 16'h0000, 1,  0,  0,  32'h0,    32'h0,    0, 0};
    vecs[4]  = '{1, 1, 3,  32'h44,   0, 16'h0000, 1,  0,  0,  32'h0,    32'h0,    0, 0};
    vecs[5]  = '{1, 1, 15, 32'hF0,   0, 16'h0000, 1,  0,  0,  32'h0,    32'h0,    0, 0};
    vecs[6]  = '{1, 0, 0,  32'h0,    1, 16'h0004, 1,  1,  1,  32'h22,   32'h33,   1, 2};
    vecs[7]  = '{1, 0, 0,  32'h0,    0, 16'h0000, 1,  1,  0,  32'h0,    32'h0,    0, 0};
    vecs[8]  = '{1, 0, 0,  32'h0,    1, 16'h0000, 0,  1,  1,  32'h11,   32'h22,   1, 2};
    vecs[9]  = '{1, 0, 0,  32'h0,    1, 16'h0004, 0,  1,  1,  32'h11,   32'h22,   1, 2};
    vecs[10] = '{1, 0, 0,  32'h0,    1, 16'h0008, 0,  0,  1,  32'h11,   32'h22,   1, 2};
    vecs[11] = '{1, 0, 0,  32'h0,    1, 16'h0008, 1,  0,  1,  32'h22,   32'h33,   1, 2};
    vecs[12] = '{1, 0, 0,  32'h0,    1, 16'h0008, 1,  1,  1,  32'h33,   32'h44,   1, 2};
    vecs[13] = '{1, 0, 0,  32'h0,    0, 16'h0000, 1,  1,  0,  32'h0,    32'h0,    0, 0};
    vecs[14] = '{1, 1, 2,  32'h55,   1, 16'h0008, 1,  0,  0,  32'h0,    32'h0,    0, 0};
    vecs[15] = '{1, 0, 0,  32'h0,    1, 16'h0008, 1,  1,  1,  32'h55,   32'h44,   1, 2};
    vecs[16] = '{1, 0, 0,  32'h0,    1, 16'h003C, 1,  1,  1,  32'hF0,   32'h13,   1, 1};
    vecs[17] = '{1, 0, 0,  32'h0,    1, 16'h0000, 0,  1,  1,  32'hF0,   32'h13,   1, 1};
    vecs[18] = '{0, 0, 0,  32'h0,    1, 16'h0000, 0,  0,  0,  32'h0,    32'h0,    0, 0};
    vecs[19] = '{1, 0, 0,  32'h0,    1, 16'h0000, 1,  1,  1,  32'h11,   32'h22,   1, 2};
    vecs[20] = '{1, 0, 0,  32'h0,    0, 16'h0000, 1,  1,  0,  32'h0,    32'h0,    0, 0};

    set_in(0, 0, 0, 0, 0, 0, 0);
    do_cycle();

    for (int i = 0; i < 21; i++) begin
      set_in(vecs[i].rst, vecs[i].le, vecs[i].la, vecs[i].ld,
             vecs[i].rv, vecs[i].ra, vecs[i].rr);
      do_cycle();
      check($sformatf("vec%0d_ready", i), {63'd0, ready_seen}, {63'd0, vecs[i].e_ready});
      check($sformatf("vec%0d_valid", i), {63'd0, valid1}, {63'd0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_lane0", i), {32'd0, instr1}, {32'd0, vecs[i].e_l0});
        check($sformatf("vec%0d_lane1", i), {32'd0, instr2[63:32]}, {32'd0, vecs[i].e_l1});
        check($sformatf("vec%0d_count1", i), {62'd0, count1}, {62'd0, vecs[i].e_c1});
        check($sformatf("vec%0d_count2", i), {62'd0, count2}, {62'd0, vecs[i].e_c2});
      end
    end

    // Misaligned and out-of-range fetches.
    set_in(1, 0, 0, 0, 1, 16'h0002, 1);
    do_cycle();
`ifdef INSTR_MEM_FAULT_EN
    check("misaligned_fault", {63'd0, fault1}, 64'd1);
    check("misaligned_instr", {32'd0, instr1}, 64'd0);
`else
    check("misaligned_alias", {32'd0, instr1}, 64'h11);
`endif
    set_in(1, 0, 0, 0, 1, 16'h0040, 1);
    do_cycle();
`ifdef INSTR_MEM_FAULT_EN
    check("range_fault", {63'd0, fault2}, 64'd1);
    check("range_count", {62'd0, count2}, 64'd1);
`else
    check("range_alias", {32'd0, instr1}, 64'h11);
`endif
    set_in(1, 0, 0, 0, 0, 0, 1);
    do_cycle();

    // Randomized phase: fill all words, then mixed traffic.
    for (int i = 0; i < 16; i++) begin
      set_in(1, 1, MDP'(i), $urandom, 0, 0, 1);
      do_cycle();
    end
    for (int i = 0; i < 800; i++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 7) == 0) a = AW'($urandom);
      else a = AW'($urandom_range(0, 15) * 4);
      set_in($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0,
             MDP'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0);
      do_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Synchronous, handshaked instruction memory. It replaces the purely combinational instruction ROM between the fetch stage and the instruction store. It accepts fetch requests over a valid/ready port and returns one or two aligned 32-bit instructions per request, one cycle later, through a 2-entry response buffer that absorbs decode-stage backpressure. A word-wide load port writes program images at run time, and optional fault detection flags misaligned or out-of-range fetch addresses.

## Interface
- ADDR_WIDTH, 64: fetch byte-address width.
- MEM_DEPTH_POW, 10: log2 of the number of 32-bit words (default 4 KB).
- FETCH_WIDTH, 1: instructions returned per request; legal values 1 or 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid_in  in  1  fetch request valid.
- req_ready_out  out  1  request can be accepted this cycle.
- req_addr_in  in  ADDR_WIDTH  fetch byte address.
- resp_valid_out  out  1  head response valid.
- resp_ready_in  in  1  consumer takes the head response.
- resp_instr_out  out  32*FETCH_WIDTH  lane 0 in bits [31:0], lane 1 in bits [63:32].
- resp_count_out  out  2  number of valid lanes, 1..FETCH_WIDTH.
- resp_fault_out  out  1  request faulted; the instruction lanes are meaningless.
- load_en_in  in  1  write one word this cycle.
- load_addr_in  in  MEM_DEPTH_POW  word index to write.
- load_data_in  in  32  word to write.

## Operation
- Storage: array of 2^MEM_DEPTH_POW 32-bit words. Reset does not clear it.
- Word index = req_addr_in >> 2, truncated to MEM_DEPTH_POW bits.
- Request acceptance: a request is accepted at a rising edge where req_valid_in && req_ready_out.
- On acceptance, the memory is read and the response is pushed into the 2-entry FIFO at that same edge.
- req_ready_out = rst_n && !load_en_in && (fifo_count < 2). It has no combinational path from resp_ready_in.
- Load port: if load_en_in is high at an edge, load_data_in is written to load_addr_in. A load always wins; no fetch is accepted in that cycle.
- Lane 0 returns mem[idx].
- Lane 1 (FETCH_WIDTH=2 only) returns mem[idx+1] and resp_count_out=2.
- Boundary at the top of memory: if idx = MEM_DEPTH-1, lane 1 does not wrap. It returns 32'h00000013 (NOP) and resp_count_out=1.
- With FETCH_WIDTH=1, resp_count_out is always 1.
- Response FIFO: the head drives the resp_* outputs. A pop happens at any edge where resp_valid_out && resp_ready_in.
- A push and a pop in the same cycle leave the count unchanged, so full rate is sustained at count 1.
- resp_valid_out = (fifo_count != 0).
- Read-after-write: a load at edge N is visible to a fetch accepted at edge N+1 or later. A response already in the FIFO keeps its captured data.

## Timing
- Latency: a request accepted at edge N has its response visible after edge N; the consumer can take it at edge N+1.
- Throughput: one request per cycle while resp_ready_in=1 and load_en_in=0.
- With resp_ready_in=0, two requests are accepted, then req_ready_out drops to 0.
- Reset: rst_n=0 at an edge empties the FIFO and discards in-flight responses, including mid-stream.
- Reset values: resp_valid_out=0, resp_instr_out=0, resp_count_out=0, resp_fault_out=0.
- req_ready_out is 0 while rst_n=0 and 1 in the first cycle after release, unless load_en_in=1.
- Memory contents survive reset.
- A held, not-yet-accepted request may change its address freely; only the address at the accepting edge matters.

## Configuration
- INSTR_MEM_FAULT_EN defined:
  - resp_fault_out=1 if req_addr_in[1:0]!=0 (misaligned) or any bit of req_addr_in[ADDR_WIDTH-1:MEM_DEPTH_POW+2] is set (out of range).
  - Faulted responses carry resp_instr_out=0 and resp_count_out=1.
  - Faulted responses occupy a FIFO slot and keep normal timing.
- INSTR_MEM_FAULT_EN undefined:
  - resp_fault_out is tied to 0.
  - Address bits [1:0] are ignored and the upper bits are truncated (aliasing).

## Test plan
- Load mem[0..3]=11,22,33,44 (hex). Fetch addr 0x4 with resp_ready_in=1 -> response after 1 edge, lane0=0x00000022, count=1, fault=0.
- Back-to-back fetches 0x0,0x4,0x8 with resp_ready_in held at 0 -> the first two are accepted and req_ready_out falls to 0. Raising resp_ready_in -> responses drain in order 11, 22, then 33 is accepted and returned.
- FETCH_WIDTH=2, fetch idx MEM_DEPTH-1 -> lane1=0x00000013, count=1. Fetch idx 2 -> lanes 33/44, count=2.
- Assert load_en_in together with req_valid_in -> req_ready_out=0 that cycle. The next fetch of the loaded word returns the new value.
- INSTR_MEM_FAULT_EN defined: fetch 0x2 -> fault=1, instr=0. Fetch 1<<(MEM_DEPTH_POW+2) -> fault=1.
- Assert rst_n=0 with 2 responses buffered -> resp_valid_out=0 next cycle. After release, memory still returns 11 at address 0.
